// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR4 command sequencer: pin encodings, FSM states,
// open-row table entry and the latched burst request.
package ddr_pkg;

  // {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14}
  localparam logic [4:0] CMD_ACT = 5'b00000;
  localparam logic [4:0] CMD_WR  = 5'b01100;
  localparam logic [4:0] CMD_RD  = 5'b01101;
  localparam logic [4:0] CMD_PRE = 5'b01010;
  localparam logic [4:0] CMD_REF = 5'b01001;
  localparam logic [4:0] CMD_DES = 5'b10111;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PRE,
    S_WAIT_RP,
    S_ACT,
    S_WAIT_RCD,
    S_CAS,
    S_WAIT_CCD,
    S_PREA,
    S_WAIT_RPA,
    S_REF,
    S_WAIT_RFC
  } seq_state_e;

  typedef enum logic [1:0] {
    LK_EMPTY    = 2'd0,
    LK_HIT      = 2'd1,
    LK_CONFLICT = 2'd2
  } lookup_e;

  typedef struct packed {
    logic        valid;
    logic [13:0] row;
  } row_entry_t;

  typedef struct packed {
    logic        wr;
    logic        bl8;
    logic [1:0]  bg;
    logic [1:0]  ba;
    logic [13:0] row;
    logic [9:0]  col;
  } burst_req_t;

endpackage

// File: rtl/bank_row_table.sv
// Open-row table: one {valid, row} entry per bank, indexed by {bg, ba}.
// Combinational lookup classifies a request as hit, empty or conflict.
module bank_row_table
  import ddr_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [3:0]  lk_idx_i,
  input  logic [13:0] lk_row_i,
  output logic [1:0]  lk_res_o,
  output logic        any_open_o,
  input  logic        set_i,
  input  logic [3:0]  set_idx_i,
  input  logic [13:0] set_row_i,
  input  logic        clr_i,
  input  logic [3:0]  clr_idx_i,
  input  logic        clr_all_i
);

  row_entry_t tbl_q [16];
  row_entry_t tbl_d [16];

  always_comb begin
    tbl_d = tbl_q;
    if (clr_all_i) begin
      for (int i = 0; i < 16; i++) tbl_d[i].valid = 1'b0;
    end else begin
      if (clr_i) tbl_d[clr_idx_i].valid = 1'b0;
      if (set_i) tbl_d[set_idx_i] = '{valid: 1'b1, row: set_row_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 16; i++) tbl_q[i] <= '0;
    end else begin
      tbl_q <= tbl_d;
    end
  end

  always_comb begin
    lk_res_o = LK_EMPTY;
    if (tbl_q[lk_idx_i].valid) begin
      lk_res_o = (tbl_q[lk_idx_i].row == lk_row_i) ? LK_HIT : LK_CONFLICT;
    end
  end

  always_comb begin
    any_open_o = 1'b0;
    for (int i = 0; i < 16; i++) any_open_o = any_open_o | tbl_q[i].valid;
  end

endmodule

// File: rtl/ddr_cmd_sequencer.sv
// DDR4 command sequencer: turns single burst / refresh requests into spaced
// PRE/ACT/RD/WR/REF commands, skipping ACT on open-row hits.
module ddr_cmd_sequencer
  import ddr_pkg::*;
#(
  parameter int T_RCD = 4,
  parameter int T_RP  = 4,
  parameter int T_CCD = 4,
  parameter int T_RFC = 8
) (
  input  logic        CK_t,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic        req_bl8,
  input  logic [1:0]  req_bg,
  input  logic [1:0]  req_ba,
  input  logic [13:0] req_row,
  input  logic [9:0]  req_col,
  input  logic        ref_req,
  output logic        ref_ack,
  output logic        cs_n,
  output logic        act_n,
  output logic        RAS_n_A16,
  output logic        CAS_n_A15,
  output logic        WE_n_A14,
  output logic [1:0]  bg_addr,
  output logic [1:0]  ba_addr,
  output logic        A13,
  output logic        A12_BC_n,
  output logic        A11,
  output logic        A10_AP,
  output logic [9:0]  A9_A0,
  output logic        no_act_rdy,
  output logic        cas_issued
);

  localparam int T_MAX_0 = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int T_MAX_1 = (T_CCD > T_RFC) ? T_CCD : T_RFC;
  localparam int T_MAX   = (T_MAX_0 > T_MAX_1) ? T_MAX_0 : T_MAX_1;
  localparam int CNT_W   = $clog2(T_MAX) + 1;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] LD_RCD  = CNT_W'(T_RCD - 1);
  localparam logic [CNT_W-1:0] LD_RP   = CNT_W'(T_RP - 1);
  localparam logic [CNT_W-1:0] LD_CCD  = CNT_W'(T_CCD - 1);
  localparam logic [CNT_W-1:0] LD_RFC  = CNT_W'(T_RFC - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  burst_req_t       req_q, req_d;
  logic             hit_q, hit_d;

  logic [4:0]  cmd_q, cmd_d;
  logic [1:0]  bg_q, bg_d, ba_q, ba_d;
  logic [13:0] addr_q, addr_d;
  logic        nar_q, nar_d, cas_q, cas_d, ack_q, ack_d;

  logic [1:0]  lk_res;
  logic        any_open;

  bank_row_table u_rows (
    .clk_i      (CK_t),
    .rst_ni     (reset_n),
    .lk_idx_i   ({req_bg, req_ba}),
    .lk_row_i   (req_row),
    .lk_res_o   (lk_res),
    .any_open_o (any_open),
    .set_i      (state_q == S_ACT),
    .set_idx_i  ({req_q.bg, req_q.ba}),
    .set_row_i  (req_q.row),
    .clr_i      (state_q == S_PRE),
    .clr_idx_i  ({req_q.bg, req_q.ba}),
    .clr_all_i  (state_q == S_PREA)
  );

  assign req_ready = reset_n & (state_q == S_IDLE) & ~ref_req;

  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      cmd_q   <= CMD_DES;
      bg_q    <= '0;
      ba_q    <= '0;
      addr_q  <= '0;
      nar_q   <= 1'b0;
      cas_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      cmd_q   <= cmd_d;
      bg_q    <= bg_d;
      ba_q    <= ba_d;
      addr_q  <= addr_d;
      nar_q   <= nar_d;
      cas_q   <= cas_d;
      ack_q   <= ack_d;
    end
  end

  // Request payload is pure data and is only consumed after being latched.
  always_ff @(posedge CK_t) begin
    req_q <= req_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    hit_d   = hit_q;
    case (state_q)
      S_IDLE: begin
        if (ref_req) begin
          state_d = any_open ? S_PREA : S_REF;
        end else if (req_valid) begin
          req_d = '{wr: req_wr, bl8: req_bl8, bg: req_bg, ba: req_ba,
                    row: req_row, col: req_col};
          hit_d = (lookup_e'(lk_res) == LK_HIT);
          case (lookup_e'(lk_res))
            LK_HIT:   state_d = S_CAS;
            LK_EMPTY: state_d = S_ACT;
            default:  state_d = S_PRE;
          endcase
        end
      end
      S_PRE: begin
        if (T_RP > 1) begin
          state_d = S_WAIT_RP;
          cnt_d   = LD_RP;
        end else state_d = S_ACT;
      end
      S_WAIT_RP: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = S_ACT;
      end
      S_ACT: begin
        if (T_RCD > 1) begin
          state_d = S_WAIT_RCD;
          cnt_d   = LD_RCD;
        end else state_d = S_CAS;
      end
      S_WAIT_RCD: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = S_CAS;
      end
      S_CAS: begin
        if (T_CCD > 1) begin
          state_d = S_WAIT_CCD;
          cnt_d   = LD_CCD;
        end else state_d = S_IDLE;
      end
      S_WAIT_CCD: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = S_IDLE;
      end
      S_PREA: begin
        if (T_RP > 1) begin
          state_d = S_WAIT_RPA;
          cnt_d   = LD_RP;
        end else state_d = S_REF;
      end
      S_WAIT_RPA: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = S_REF;
      end
      S_REF: begin
        state_d = S_WAIT_RFC;
        cnt_d   = LD_RFC;
      end
      // One cycle longer than the other waits: ref_ack occupies the last
      // cycle so the controller can drop ref_req before IDLE samples it.
      S_WAIT_RFC: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else cnt_d = cnt_q - CNT_ONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Pins are registered from the next state so each command lands the cycle
  // after the state decision, and lasts exactly one cycle.
  always_comb begin
    cmd_d  = CMD_DES;
    bg_d   = '0;
    ba_d   = '0;
    addr_d = '0;
    nar_d  = 1'b0;
    cas_d  = 1'b0;
    ack_d  = 1'b0;
    case (state_d)
      S_ACT: begin
        cmd_d  = CMD_ACT;
        bg_d   = req_d.bg;
        ba_d   = req_d.ba;
        addr_d = req_d.row;
      end
      S_CAS: begin
        cmd_d  = req_d.wr ? CMD_WR : CMD_RD;
        bg_d   = req_d.bg;
        ba_d   = req_d.ba;
        addr_d = {1'b0, req_d.bl8, 1'b0, 1'b0, req_d.col};
        nar_d  = hit_d;
        cas_d  = 1'b1;
      end
      S_PRE: begin
        cmd_d = CMD_PRE;
        bg_d  = req_d.bg;
        ba_d  = req_d.ba;
      end
      S_PREA: begin
        cmd_d  = CMD_PRE;
        addr_d = 14'h0400;
      end
      S_REF:      cmd_d = CMD_REF;
      S_WAIT_RFC: ack_d = (cnt_d == '0);
      default: ;
    endcase
  end

  assign {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14} = cmd_q;
  assign bg_addr    = bg_q;
  assign ba_addr    = ba_q;
  assign {A13, A12_BC_n, A11, A10_AP, A9_A0} = addr_q;
  assign no_act_rdy = nar_q;
  assign cas_issued = cas_q;
  assign ref_ack    = ack_q;

endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// Bench for ddr_cmd_sequencer: directed scenarios plus random bursts, checked
// against an open-row reference model and cycle offsets derived from tRCD/tRP/tCCD/tRFC.
module tb_ddr_cmd_sequencer;

  localparam int T_RCD = 4;
  localparam int T_RP  = 4;
  localparam int T_CCD = 4;
  localparam int T_RFC = 8;

  localparam logic [4:0] C_ACT = 5'b00000;
  localparam logic [4:0] C_WR  = 5'b01100;
  localparam logic [4:0] C_RD  = 5'b01101;
  localparam logic [4:0] C_PRE = 5'b01010;
  localparam logic [4:0] C_REF = 5'b01001;
  localparam logic [25:0] DES  = {5'b10111, 21'd0};

  logic        CK_t = 1'b0;
  logic        reset_n = 1'b1;
  logic        req_valid = 1'b0, req_wr = 1'b0, req_bl8 = 1'b0;
  logic [1:0]  req_bg = '0, req_ba = '0;
  logic [13:0] req_row = '0;
  logic [9:0]  req_col = '0;
  logic        ref_req = 1'b0;
  logic        req_ready, ref_ack;
  logic        cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14;
  logic [1:0]  bg_addr, ba_addr;
  logic        A13, A12_BC_n, A11, A10_AP;
  logic [9:0]  A9_A0;
  logic        no_act_rdy, cas_issued;

  int checks = 0;
  int fails  = 0;

  // Reference model: which row each bank {bg,ba} holds open.
  bit          mv [16];
  logic [13:0] mr [16];

  ddr_cmd_sequencer #(.T_RCD(T_RCD), .T_RP(T_RP), .T_CCD(T_CCD), .T_RFC(T_RFC)) dut (
    .CK_t(CK_t), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_bl8(req_bl8),
    .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
    .ref_req(ref_req), .ref_ack(ref_ack),
    .cs_n(cs_n), .act_n(act_n), .RAS_n_A16(RAS_n_A16), .CAS_n_A15(CAS_n_A15), .WE_n_A14(WE_n_A14),
    .bg_addr(bg_addr), .ba_addr(ba_addr),
    .A13(A13), .A12_BC_n(A12_BC_n), .A11(A11), .A10_AP(A10_AP), .A9_A0(A9_A0),
    .no_act_rdy(no_act_rdy), .cas_issued(cas_issued)
  );

  always #5 CK_t = ~CK_t;

  task automatic tick();
    @(negedge CK_t);
  endtask

  function automatic logic [25:0] obs();
    return {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14, bg_addr, ba_addr,
            A13, A12_BC_n, A11, A10_AP, A9_A0, no_act_rdy, cas_issued, ref_ack};
  endfunction

  function automatic logic [25:0] ev(input logic [4:0] c, input logic [1:0] g, input logic [1:0] b,
                                     input logic [13:0] a, input logic nar, input logic cas,
                                     input logic ack);
    return {c, g, b, a, nar, cas, ack};
  endfunction

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
  endtask

  // Present one burst, wait (bounded) for acceptance, then check every cycle
  // up to the CAS and the cycle req_ready returns.
  task automatic do_req(input string tg, input logic wr, input logic bl8, input logic [1:0] g,
                        input logic [1:0] b, input logic [13:0] row, input logic [9:0] col,
                        output int waited);
    int          idx, n, e, last;
    int          off [3];
    logic [25:0] exp_ev [3];
    logic [4:0]  cas_cmd;
    bit          gap_ok, rdy_ok;
    req_valid = 1'b1; req_wr = wr; req_bl8 = bl8;
    req_bg = g; req_ba = b; req_row = row; req_col = col;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 200) begin
      tick();
      waited++;
    end
    chk({tg, "_accept"}, {63'd0, req_ready}, 64'd1);
    if (req_ready !== 1'b1) begin
      req_valid = 1'b0;
      return;
    end
    idx = int'({g, b});
    cas_cmd = wr ? C_WR : C_RD;
    n = 0;
    if (mv[idx] && mr[idx] == row) begin
      off[0] = 1;
      exp_ev[0] = ev(cas_cmd, g, b, {1'b0, bl8, 2'b00, col}, 1'b1, 1'b1, 1'b0);
      n = 1;
    end else begin
      if (mv[idx]) begin
        off[0] = 1;
        exp_ev[0] = ev(C_PRE, g, b, 14'd0, 1'b0, 1'b0, 1'b0);
        n = 1;
      end
      off[n] = (n == 0) ? 1 : 1 + T_RP;
      exp_ev[n] = ev(C_ACT, g, b, row, 1'b0, 1'b0, 1'b0);
      n++;
      off[n] = off[n-1] + T_RCD;
      exp_ev[n] = ev(cas_cmd, g, b, {1'b0, bl8, 2'b00, col}, 1'b0, 1'b1, 1'b0);
      n++;
      mv[idx] = 1'b1;
      mr[idx] = row;
    end
    last = off[n-1];
    tick();
    req_valid = 1'b0;
    gap_ok = 1'b1;
    e = 0;
    for (int k = 1; k <= last; k++) begin
      if (e < n && k == off[e]) begin
        chk($sformatf("%s_cmd%0d", tg, e), {38'd0, obs()}, {38'd0, exp_ev[e]});
        e++;
      end else if (obs() !== DES) gap_ok = 1'b0;
      tick();
    end
    chk({tg, "_gaps"}, {63'd0, gap_ok}, 64'd1);
    rdy_ok = 1'b1;
    for (int j = last + 1; j <= last + T_CCD; j++) begin
      if (req_ready !== (j == last + T_CCD)) rdy_ok = 1'b0;
      if (j != last + T_CCD) begin
        if (obs() !== DES) rdy_ok = 1'b0;
        tick();
      end
    end
    chk({tg, "_tccd_ready"}, {63'd0, rdy_ok}, 64'd1);
  endtask

  // Raise ref_req from IDLE; expect PREA only when the model has an open bank.
  task automatic do_ref(input string tg);
    int ref_off, ack_off;
    bit anyo, gap_ok;
    anyo = 1'b0;
    for (int i = 0; i < 16; i++) if (mv[i]) anyo = 1'b1;
    ref_req = 1'b1;
    #1;
    chk({tg, "_ready_low"}, {63'd0, req_ready}, 64'd0);
    ref_off = anyo ? 1 + T_RP : 1;
    ack_off = ref_off + T_RFC;
    model_clear();
    gap_ok = 1'b1;
    for (int k = 1; k <= ack_off; k++) begin
      tick();
      if (anyo && k == 1)
        chk({tg, "_prea"}, {38'd0, obs()}, {38'd0, ev(C_PRE, 2'd0, 2'd0, 14'h0400, 1'b0, 1'b0, 1'b0)});
      else if (k == ref_off)
        chk({tg, "_ref"}, {38'd0, obs()}, {38'd0, ev(C_REF, 2'd0, 2'd0, 14'd0, 1'b0, 1'b0, 1'b0)});
      else if (k == ack_off)
        chk({tg, "_ack"}, {38'd0, obs()}, {38'd0, DES | 26'd1});
      else if (obs() !== DES) gap_ok = 1'b0;
    end
    ref_req = 1'b0;
    tick();
    chk({tg, "_gaps"}, {63'd0, gap_ok}, 64'd1);
    chk({tg, "_ready_back"}, {63'd0, req_ready}, 64'd1);
    chk({tg, "_ack_pulse"}, {38'd0, obs()}, {38'd0, DES});
  endtask

  initial begin
    int          w;
    bit          quiet;
    logic [13:0] rowtab [4];
    logic [1:0]  g, b;
    rowtab[0] = 14'h0011; rowtab[1] = 14'h1A2B; rowtab[2] = 14'h3FFF; rowtab[3] = 14'h0200;
    model_clear();

    #2 reset_n = 1'b0;
    tick();
    tick();
    chk("reset_pins", {38'd0, obs()}, {38'd0, DES});
    chk("reset_ready", {63'd0, req_ready}, 64'd0);
    reset_n = 1'b1;
    tick();
    chk("post_reset_ready", {63'd0, req_ready}, 64'd1);

    do_req("rd_empty", 1'b0, 1'b0, 2'd1, 2'd2, 14'h0123, 10'h040, w);
    do_req("wr_hit",   1'b1, 1'b1, 2'd1, 2'd2, 14'h0123, 10'h080, w);
    do_req("rd_conf",  1'b0, 1'b0, 2'd1, 2'd2, 14'h0456, 10'h040, w);
    do_req("open2",    1'b1, 1'b0, 2'd0, 2'd0, 14'h0007, 10'h3FF, w);
    do_ref("ref_open");
    do_req("after_ref", 1'b0, 1'b1, 2'd1, 2'd2, 14'h0456, 10'h010, w);

    req_valid = 1'b1; req_wr = 1'b1; req_bl8 = 1'b0;
    req_bg = 2'd2; req_ba = 2'd3; req_row = 14'h0222; req_col = 10'h001;
    do_ref("ref_both");
    do_req("both_req", 1'b1, 1'b0, 2'd2, 2'd3, 14'h0222, 10'h001, w);
    chk("both_no_wait", 64'(w), 64'd0);

    req_valid = 1'b1; req_wr = 1'b0; req_bl8 = 1'b1;
    req_bg = 2'd3; req_ba = 2'd1; req_row = 14'h3ABC; req_col = 10'h155;
    w = 0;
    while (req_ready !== 1'b1 && w < 200) begin
      tick();
      w++;
    end
    chk("rst_accept", {63'd0, req_ready}, 64'd1);
    tick();
    req_valid = 1'b0;
    chk("rst_act", {38'd0, obs()}, {38'd0, ev(C_ACT, 2'd3, 2'd1, 14'h3ABC, 1'b0, 1'b0, 1'b0)});
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    chk("rst_mid_pins", {38'd0, obs()}, {38'd0, DES});
    chk("rst_mid_ready", {63'd0, req_ready}, 64'd0);
    tick();
    tick();
    reset_n = 1'b1;
    model_clear();
    quiet = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (obs() !== DES) quiet = 1'b0;
    end
    chk("rst_no_partial", {63'd0, quiet}, 64'd1);
    do_req("rst_reopen", 1'b0, 1'b1, 2'd3, 2'd1, 14'h3ABC, 10'h155, w);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(7) == 0) do_ref($sformatf("rnd%0d_ref", i));
      g = 2'($urandom_range(3));
      b = 2'($urandom_range(1));
      do_req($sformatf("rnd%0d", i), 1'($urandom_range(1)), 1'($urandom_range(1)), g, b,
             rowtab[$urandom_range(3)], 10'($urandom_range(1023)), w);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/ddr_cmd_sequencer.md
# ddr_cmd_sequencer

Front-end command generator that sits directly upstream of the DIMM model. It accepts single read/write burst requests and refresh requests from the controller. It tracks the open row of each of the 16 banks and drives the DDR4 command/address pins with correctly spaced PRE / ACT / RD / WR / REF commands. On row hits it skips ACT and pulses `no_act_rdy` so the DIMM side can still pair the CAS with its row address.

## Interface
Parameters:
- `T_RCD`, 4 — cycles from ACT to CAS.
- `T_RP`, 4 — cycles from PRE/PREA to ACT or REF.
- `T_CCD`, 4 — minimum cycles from a CAS to the next command of any kind.
- `T_RFC`, 8 — cycles from REF to the next command.

Ports (clock and reset: one clock `CK_t`; reset `reset_n` is asynchronous, active-low):
- `CK_t` in 1 — command clock; all state updates on its rising edge.
- `reset_n` in 1 — asynchronous active-low reset.
- `req_valid` in 1 — burst request present.
- `req_ready` out 1 — request accepted when high together with `req_valid`.
- `req_wr` in 1 — 1 = write, 0 = read.
- `req_bl8` in 1 — 1 = BL8 (`A12_BC_n` = 1 on CAS), 0 = BC4.
- `req_bg` in 2 — bank group.
- `req_ba` in 2 — bank.
- `req_row` in 14 — row address.
- `req_col` in 10 — column address.
- `ref_req` in 1 — level; refresh wanted.
- `ref_ack` out 1 — one-cycle pulse when the refresh sequence completes.
- `cs_n`, `act_n`, `RAS_n_A16`, `CAS_n_A15`, `WE_n_A14` out 1 each — command pins.
- `bg_addr` out 2, `ba_addr` out 2 — bank pins.
- `A13`, `A12_BC_n`, `A11`, `A10_AP` out 1 each; `A9_A0` out 10 — address pins.
- `no_act_rdy` out 1 — pulse coincident with a CAS issued on a row hit.
- `cas_issued` out 1 — pulse coincident with every RD/WR.

## Operation
- Command encodings, as {`cs_n`, `act_n`, `RAS`, `CAS`, `WE`}:
  - ACT = 0,0,row[16:14 slots].
  - WR = 01100; RD = 01101; PRE = 01010; REF = 01001.
  - Deselect = 10111, with all address pins 0.
- Every command is driven for exactly one cycle; all other cycles drive deselect.
- Address mapping:
  - ACT: `A13..A0` = `req_row`.
  - CAS: `A9_A0` = `req_col`, `A10_AP` = 0, `A12_BC_n` = `req_bl8`.
  - PRE: `A10_AP` = 0 for a single bank; PREA uses `A10_AP` = 1.
- Open-row table: 16 entries indexed {bg, ba}, each with a valid bit and a 14-bit row.
  - Set on ACT.
  - Cleared on PRE of that bank.
  - All cleared on PREA and on reset.
- FSM states: IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, CAS, WAIT_CCD, PREA, WAIT_RPA, REF, WAIT_RFC.
- IDLE with `ref_req` = 1 (refresh has priority over a simultaneous request):
  - Go to PREA if any bank is open, otherwise go to REF.
- IDLE, request accepted (`ref_req` = 0), the request is latched, then:
  - Hit (entry valid, rows equal) → CAS.
  - Empty (entry invalid) → ACT.
  - Conflict (entry valid, rows differ) → PRE.
- Other transitions:
  - PRE → WAIT_RP → ACT.
  - ACT → WAIT_RCD → CAS.
  - CAS → WAIT_CCD → IDLE.
  - PREA → WAIT_RPA → REF.
  - REF → WAIT_RFC → IDLE, with `ref_ack` pulsed on the cycle WAIT_RFC exits.
- `req_ready` = `reset_n` AND (state == IDLE) AND NOT `ref_req`.
- `ref_req` arriving mid-sequence is served only after the current request reaches IDLE; a request in flight is never aborted.

## Timing
- Request accepted at edge N; the first command appears at N+1:
  - Hit: CAS at N+1.
  - Empty: ACT at N+1, CAS at N+1+T_RCD.
  - Conflict: PRE at N+1, ACT at N+1+T_RP, CAS at N+1+T_RP+T_RCD.
- After a CAS at cycle C, `req_ready` is high again at C+T_CCD. Back-to-back hits therefore issue one CAS every T_CCD+1 cycles.
- Refresh: REF at R; `ref_ack` at R+T_RFC; `req_ready` at R+T_RFC+1.
- Wait counters:
  - Width is clog2(max parameter)+1.
  - Loaded with (param−1) on entry to a wait state; the state exits when the counter reaches 0.
  - A parameter value of 1 means no wait state beyond the command cycle.
- Reset (asserted at any time, including mid-sequence): immediately force the following, with no partial command emitted after release.
  - Deselect on the pins and all address outputs 0.
  - `no_act_rdy`, `cas_issued`, `ref_ack`, `req_ready` = 0.
  - Open-row table cleared; FSM in IDLE.
- All outputs are registered.

## Structure
- Shared package `ddr_pkg`:
  - 5-bit command encoding constants (ACT/WR/RD/PRE/REF/DES).
  - FSM state enum `seq_state_e`.
  - Open-row entry struct {valid, row[13:0]}.
- One sub-module: `bank_row_table`, holding the 16-entry open-row table.
  - Lookup port returns hit/empty/conflict.
  - Write ports: set, clear-one, clear-all.

## Test plan
- Reset, then read bg=1 ba=2 row=0x0123 col=0x040:
  - ACT with `A13..A0` = 0x0123 at N+1.
  - RD = 01101 with `A9_A0` = 0x040 at N+5.
  - `no_act_rdy` stays 0.
- Same bank, same row, write col=0x080 BL8:
  - WR at N+1 with `A12_BC_n` = 1.
  - `no_act_rdy` and `cas_issued` high that cycle.
- Same bank, row 0x0456:
  - PRE (`A10_AP` = 0) at N+1, ACT at N+5, RD at N+9.
- `ref_req` raised with two banks open:
  - PREA (`A10_AP` = 1), then REF 4 cycles later, then `ref_ack` 8 cycles after REF.
  - A subsequent request to a previously open bank issues ACT, not CAS.
- `ref_req` and `req_valid` both high in IDLE:
  - `req_ready` = 0 and refresh runs first; the request is accepted the cycle after `ref_ack`.
- `reset_n` dropped during WAIT_RCD:
  - Pins go to deselect in the same cycle.
  - After release, a request to that bank issues ACT (table cleared).
